// File: rtl/sfilt_pkg.sv
// Shared definitions for the serial filter and its command sequencer.
// Holds the sfilt command encoding, the sequencer state type and the
// operand width used on the q/h datapath.
package sfilt_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] CMD_FIRST = 2'd0;
  localparam logic [1:0] CMD_MAC   = 2'd1;
  localparam logic [1:0] CMD_SHIFT = 2'd2;
  localparam logic [1:0] CMD_OUT   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_EMIT  = 2'd3
  } state_t;

endpackage

// File: rtl/sfilt_dline.sv
// Circular sample delay line for the sfilt command sequencer.
// Ports:
//   clk, rst  - clock and synchronous active-high reset (clears every slot
//               and both pointers)
//   we, din   - write strobe and sample; din lands in the next free slot
//   rd_off    - tap age (0 = newest sample)
//   rd_data   - combinational read of the sample rd_off positions older
//               than the newest one
module sfilt_dline
  import sfilt_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int AW    = $clog2(NTAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic signed [DATA_W-1:0] din,
  input  logic        [AW-1:0]     rd_off,
  output logic signed [DATA_W-1:0] rd_data
);

  localparam logic [AW:0]   NT   = (AW + 1)'(NTAPS);
  localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

  logic signed [DATA_W-1:0] mem [NTAPS];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] newest;
  logic [AW:0]   sum;
  logic [AW:0]   idx;
  logic          unused_msb;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      newest <= '0;
      for (int i = 0; i < NTAPS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_ptr] <= din;
      newest      <= wr_ptr;
      wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
    end
  end

  // (newest - rd_off) mod NTAPS without a divider: bias by NTAPS so the
  // difference stays positive, then fold once. Works for any NTAPS, not
  // only powers of two, and never produces an index above NTAPS-1.
  always_comb begin
    sum = {1'b0, newest} + NT - {1'b0, rd_off};
    idx = (sum >= NT) ? (sum - NT) : sum;
  end

  assign rd_data    = mem[idx[AW-1:0]];
  assign unused_msb = idx[AW];

endmodule

// File: rtl/sfilt_seq.sv
// Command sequencer feeding sfilt. Each accepted sample produces one burst:
// first-mult, NTAPS-1 mult-accumulates, shift/round, output/clear, issued on
// consecutive cycles with no bubbles.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   pushin, x, shamt    - sample handshake, sample value, per-sample shift
//   ready               - high while idle (combinational from state)
//   cwe, caddr, cdata   - coefficient write port, honoured only while idle
//   pushout, cmd, q, h  - registered command stream to sfilt
module sfilt_seq
  import sfilt_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int AW    = $clog2(NTAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pushin,
  input  logic signed [DATA_W-1:0] x,
  input  logic        [6:0]        shamt,
  output logic                     ready,
  input  logic                     cwe,
  input  logic        [AW-1:0]     caddr,
  input  logic signed [DATA_W-1:0] cdata,
  output logic                     pushout,
  output logic        [1:0]        cmd,
  output logic signed [DATA_W-1:0] q,
  output logic signed [DATA_W-1:0] h
);

  localparam logic [AW:0]   NT   = (AW + 1)'(NTAPS);
  localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

  state_t                   state;
  logic        [AW-1:0]     k;
  logic        [6:0]        shamt_r;
  logic signed [DATA_W-1:0] coef [NTAPS];
  logic signed [DATA_W-1:0] tap_q;
  logic signed [DATA_W-1:0] coef0;
  logic                     accept;
  logic                     cwr;

  assign ready  = (state == ST_IDLE);
  assign accept = ready && pushin;
  assign cwr    = ready && cwe && ({1'b0, caddr} < NT);

  // A coefficient write in the accept cycle must be seen by the cmd0 it
  // coincides with, so tap 0 is forwarded from the write port.
  assign coef0 = (cwr && (caddr == '0)) ? cdata : coef[0];

  sfilt_dline #(
    .NTAPS (NTAPS),
    .AW    (AW)
  ) u_dline (
    .clk     (clk),
    .rst     (rst),
    .we      (accept),
    .din     (x),
    .rd_off  (k),
    .rd_data (tap_q)
  );

  // Command register stage: everything sfilt sees is launched from here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      k       <= '0;
      shamt_r <= '0;
      pushout <= 1'b0;
      cmd     <= CMD_FIRST;
      q       <= '0;
      h       <= '0;
      for (int i = 0; i < NTAPS; i++) coef[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cwr) coef[caddr] <= cdata;
          if (pushin) begin
            // cmd0 takes the incoming sample directly; the delay line
            // write lands on this same edge.
            shamt_r <= shamt;
            pushout <= 1'b1;
            cmd     <= CMD_FIRST;
            q       <= x;
            h       <= coef0;
            k       <= AW'(1);
            state   <= ST_MAC;
          end else begin
            // cmd/q/h deliberately hold their last values between bursts.
            pushout <= 1'b0;
          end
        end
        ST_MAC: begin
          pushout <= 1'b1;
          cmd     <= CMD_MAC;
          q       <= tap_q;
          h       <= coef[k];
          if (k == LAST) state <= ST_SHIFT;
          else           k     <= k + AW'(1);
        end
        ST_SHIFT: begin
          pushout <= 1'b1;
          cmd     <= CMD_SHIFT;
          q       <= '0;
          h       <= $signed({25'b0, shamt_r});
          state   <= ST_EMIT;
        end
        default: begin
          pushout <= 1'b1;
          cmd     <= CMD_OUT;
          q       <= '0;
          h       <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfilt_seq.sv
// Scoreboard bench for sfilt_seq (NTAPS = 8). Stimulus queues the expected
// command stream, each entry stamped with the cycle it must appear in; a
// monitor on the falling edge pops and compares whenever pushout is high.
module tb_sfilt_seq;
  import sfilt_pkg::*;

  localparam int NTAPS = 8;
  localparam int AW    = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     pushin = 1'b0;
  logic signed [DATA_W-1:0] x = '0;
  logic        [6:0]        shamt = '0;
  logic                     ready;
  logic                     cwe = 1'b0;
  logic        [AW-1:0]     caddr = '0;
  logic signed [DATA_W-1:0] cdata = '0;
  logic                     pushout;
  logic        [1:0]        cmd;
  logic signed [DATA_W-1:0] q;
  logic signed [DATA_W-1:0] h;

  sfilt_seq #(.NTAPS(NTAPS), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .pushin  (pushin),
    .x       (x),
    .shamt   (shamt),
    .ready   (ready),
    .cwe     (cwe),
    .caddr   (caddr),
    .cdata   (cdata),
    .pushout (pushout),
    .cmd     (cmd),
    .q       (q),
    .h       (h)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [1:0]  cmd;
    int          q;
    int          h;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   idle_zero = 1'b0;

  // Reference state: coefficient image and every sample accepted since reset.
  int   mcoef [NTAPS];
  int   hist[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (pushout === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pushout cyc=%0d got cmd=%0d q=%0d h=%0d", cyc, cmd, q, h);
      end else begin
        e = sb.pop_front();
        if (cmd !== e.cmd || q !== e.q || h !== e.h || cyc != e.cyc ||
            ready !== (e.cmd == CMD_OUT)) begin
          errors++;
          $display("FAIL burst got cyc=%0d cmd=%0d q=%0d h=%0d ready=%b required cyc=%0d cmd=%0d q=%0d h=%0d ready=%0d",
                   cyc, cmd, q, h, ready, e.cyc, e.cmd, e.q, e.h, (e.cmd == CMD_OUT));
        end
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      checks++;
      errors++;
      e = sb.pop_front();
      $display("FAIL missing_cmd cyc=%0d got pushout=%b required cmd=%0d at cyc=%0d", cyc, pushout, e.cmd, e.cyc);
    end else if (idle_zero) begin
      checks++;
      if (ready !== 1'b1 || pushout !== 1'b0 || cmd !== 2'd0 || q !== 0 || h !== 0) begin
        errors++;
        $display("FAIL idle_zero cyc=%0d got ready=%b pushout=%b cmd=%0d q=%0d h=%0d required 1 0 0 0 0",
                 cyc, ready, pushout, cmd, q, h);
      end
    end
  end

  task automatic wcoef(input int a, input int d);
    @(negedge clk);
    cwe = 1'b1; caddr = AW'(a); cdata = d;
    mcoef[a] = d;
    @(posedge clk); #1;
    cwe = 1'b0;
  endtask

  // Present a sample (optionally with a coefficient write) and queue its burst.
  task automatic send(input int xv, input int sh, input bit wr, input int ca, input int cd);
    int n;
    int base;
    exp_t e;
    pushin = 1'b1; x = xv; shamt = 7'(sh);
    cwe = wr; caddr = AW'(ca); cdata = cd;
    @(negedge clk);
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      $display("FAIL ready_timeout got ready=%b required 1 within 100 cycles", ready);
      $fatal(1);
    end
    if (wr && ca < NTAPS) mcoef[ca] = cd;
    hist.push_back(xv);
    base = cyc + 1;
    e.cyc = base; e.cmd = CMD_FIRST; e.q = xv; e.h = mcoef[0];
    sb.push_back(e);
    for (int t = 1; t < NTAPS; t++) begin
      int idx;
      idx = hist.size() - 1 - t;
      e.cyc = base + t; e.cmd = CMD_MAC;
      e.q = (idx >= 0) ? hist[idx] : 0;
      e.h = mcoef[t];
      sb.push_back(e);
    end
    e.cyc = base + NTAPS;     e.cmd = CMD_SHIFT; e.q = 0; e.h = sh; sb.push_back(e);
    e.cyc = base + NTAPS + 1; e.cmd = CMD_OUT;   e.q = 0; e.h = 0;  sb.push_back(e);
    @(posedge clk); #1;
    pushin = 1'b0; cwe = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < NTAPS; i++) mcoef[i] = 0;

    // Reset then five quiet cycles with all outputs at zero.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle_zero = 1'b1;
    repeat (5) @(posedge clk);
    #1 idle_zero = 1'b0;

    // coef[k] = k+1, then a lone sample: q=5,0..., h=1..8,3,0.
    for (int i = 0; i < NTAPS; i++) wcoef(i, i + 1);
    send(5, 3, 1'b0, 0, 0);

    // Ten samples back to back; bursts must abut and the 10th wraps.
    for (int s = 1; s <= 10; s++) send(s, 3, 1'b0, 0, 0);

    // Coefficient write while busy is dropped.
    send(11, 3, 1'b0, 0, 0);
    cwe = 1'b1; caddr = 3'd2; cdata = 99;
    repeat (3) @(posedge clk);
    #1 cwe = 1'b0;
    send(12, 3, 1'b0, 0, 0);

    // Same write together with pushin in idle takes effect for this burst.
    send(13, 3, 1'b1, 2, 99);

    // Negative sample and a different shift amount.
    send(-6, 17, 1'b0, 0, 0);

    // Reset in the middle of a burst.
    send(14, 3, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    hist.delete();
    for (int i = 0; i < NTAPS; i++) mcoef[i] = 0;
    rst = 1'b0;
    idle_zero = 1'b1;
    repeat (2) @(posedge clk);
    #1 idle_zero = 1'b0;
    send(7, 3, 1'b0, 0, 0);

    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      $display("FAIL drain_timeout got %0d pending required 0", sb.size());
      $fatal(1);
    end
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sfilt_seq.md
# sfilt_seq

Upstream command sequencer for the serial filter (`sfilt`). It accepts one input sample at a time and holds an NTAPS-deep circular delay line plus an NTAPS-entry coefficient RAM. For each accepted sample it emits the full `sfilt` command burst: first-mult, NTAPS-1 mult-accumulates, shift/round, then output/clear. Its outputs connect directly to `sfilt`'s `pushin/cmd/q/h`.

## Interface
- `NTAPS`, 8: filter length; legal range 2..64, not required to be a power of 2.
- `AW`, `$clog2(NTAPS)`: coefficient and pointer address width.
- `clk` in 1: single clock; all logic is posedge.
- `rst` in 1: synchronous, active-high reset.
- `pushin` in 1: sample valid; accepted only when `ready`=1.
- `x` in 32: signed sample.
- `shamt` in 7: right-shift count for this sample's cmd2; captured at accept.
- `ready` out 1: high in IDLE only; combinational from state.
- `cwe` in 1: coefficient write strobe; honoured only when `ready`=1.
- `caddr` in AW: coefficient index; values ≥ NTAPS are ignored.
- `cdata` in 32: signed coefficient.
- `pushout` out 1: command valid to `sfilt`.
- `cmd` out 2: 0 first mult, 1 mult-acc, 2 shift/round, 3 output/clear.
- `q` out 32: sample operand.
- `h` out 32: coefficient operand, or `{25'b0,shamt}` for cmd2.

## Operation
- States: IDLE, MAC, SHIFT, EMIT.
- Registers: `buf[NTAPS]`, `coef[NTAPS]`, `wr_ptr` (next slot to write), `newest` (slot of the latest sample), `k` (tap counter), `shamt_r`.
- IDLE with `pushin`:
  - `buf[wr_ptr]<=x`, `newest<=wr_ptr`.
  - `wr_ptr<=(wr_ptr+1) mod NTAPS`, `shamt_r<=shamt`.
  - Issue cmd0 with `q=x` (bypass) and `h=coef[0]`.
  - `k<=1`; next state MAC.
- MAC: issue cmd1 with `q=buf[(newest-k) mod NTAPS]` and `h=coef[k]`, then `k++`. After `k=NTAPS-1` is issued, go to SHIFT.
- SHIFT: issue cmd2 with `q=0` and `h={25'b0,shamt_r}`; go to EMIT.
- EMIT: issue cmd3 with `q=0`, `h=0`; go to IDLE.
- Wrap: the pointer subtraction is modulo NTAPS and never indexes past NTAPS-1. Slots never written since reset read 0.
- `cwe` in IDLE writes `coef[caddr]<=cdata`.
- `cwe` and `pushin` in the same IDLE cycle: the coefficient write takes effect first. The cmd0 issued that cycle uses the new value if `caddr`=0.
- `cwe` while busy is dropped silently. `pushin` while busy is not accepted; the source holds the sample.
- `pushout`=0 in IDLE unless a sample is accepted. In that case `cmd`/`q`/`h` hold their previous values.

## Timing
- All outputs except `ready` are registered.
- A sample accepted at the edge closing cycle T produces:
  - cmd0 visible in T+1;
  - cmd1s in T+2..T+NTAPS;
  - cmd2 in T+NTAPS+1;
  - cmd3 in T+NTAPS+2.
- `ready`=1 during the cmd3 cycle. Samples presented back-to-back give gapless bursts, one sample per NTAPS+2 cycles.
- `pushout` is asserted every cycle of a burst with no bubbles (`sfilt` has no backpressure).
- Reset values:
  - `pushout=0`, `cmd=0`, `q=0`, `h=0`, `ready=1`, state IDLE;
  - `wr_ptr=0`, `newest=0`, `k=0`, `shamt_r=0`;
  - all `buf` and `coef` entries = 0.
- Reset mid-burst aborts it. `pushout` is 0 from the cycle after the reset edge, and no partial cmd3 is issued.

## Structure
- Shared `sfilt_pkg` holds:
  - `CMD_FIRST=2'd0`, `CMD_MAC=2'd1`, `CMD_SHIFT=2'd2`, `CMD_OUT=2'd3`;
  - a state enum typedef.
  - `sfilt` itself adopts the command constants.
- One sub-module, `sfilt_dline`: circular buffer with write port, `wr_ptr`/`newest` management, modulo read index, and synchronous clear on `rst`.
- `coef` RAM and FSM stay in the top module.

## Test plan
- Reset, then idle for 5 cycles: all outputs 0, `ready`=1, no `pushout`.
- NTAPS=8, `coef[k]=k+1`, `shamt`=3, single sample `x`=5:
  - cmd sequence 0,1×7,2,3 on ten consecutive cycles;
  - `q`=5,0,0,0,0,0,0,0,0,0;
  - `h`=1..8, then 3, then 0.
- Samples 1..10 with `pushin` held high:
  - bursts abut with no gaps;
  - the 10th burst `q` is 10,9,8,7,6,5,4,3 (wrap verified).
- `cwe` (`caddr`=2, `cdata`=99) during a burst: dropped; `h` for tap 2 stays 3 on the next burst.
- Same write issued together with `pushin` in IDLE: that burst shows `h`=99 at tap 2.
- `rst` asserted at tap 4 of a burst:
  - `pushout`=0 next cycle;
  - the next sample `x`=7 gives `q`=7,0,0,…;
  - `h` all 0, because `coef` is cleared.
